// File: rtl/spi_command_receiver.sv
// SPI mode-0 target that turns MOSI into command bytes and returns status on MISO.
// Ports:
//   clk, reset (async, active-low)
//   sclk/cs_n/mosi in, miso out: SPI pins, asynchronous to clk
//   command_out/command_out_valid: one-cycle strobe per received byte
//   fifo_count: downstream FIFO occupancy, used for the free-slot field
//   invalid_command: sticky-latched into the status byte
//   overflow/framing_error: sticky error flags
module spi_command_receiver #(
  parameter int sync_stages     = 2,
  parameter int spi_fifo_length = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sclk,
  input  logic                               cs_n,
  input  logic                               mosi,
  output logic                               miso,
  output logic [7:0]                         command_out,
  output logic                               command_out_valid,
  input  logic [$clog2(spi_fifo_length):0]   fifo_count,
  input  logic                               invalid_command,
  output logic                               overflow,
  output logic                               framing_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COMPLETE
  } state_t;

  state_t state;

  logic [sync_stages-1:0] sclk_q;
  logic [sync_stages-1:0] cs_q;
  logic [sync_stages-1:0] mosi_q;
  logic sclk_d;
  logic cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  logic [3:0] bit_cnt;
  logic [7:0] rx;
  logic [6:0] tx;
  logic       inv_flag;
  logic [2:0] rep;

  logic        room;
  logic [31:0] free_w;
  logic [4:0]  free;
  logic        set_ovf;
  logic        set_frm;
  logic [2:0]  clr;
  logic        ovf_nx;
  logic        inv_nx;
  logic        frm_nx;
  logic [7:0]  status;

  // Synchronisers idle at the quiescent line levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[sync_stages-2:0], sclk};
      cs_q   <= {cs_q[sync_stages-2:0], cs_n};
      mosi_q <= {mosi_q[sync_stages-2:0], mosi};
      sclk_d <= sclk_q[sync_stages-1];
      cs_d   <= cs_q[sync_stages-1];
    end
  end

  assign sclk_s    = sclk_q[sync_stages-1];
  assign cs_s      = cs_q[sync_stages-1];
  assign mosi_s    = mosi_q[sync_stages-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // Flags are built from their next values so a status byte loaded
  // in the same cycle a flag is set already reports it (set wins).
  always_comb begin
    room    = 32'(fifo_count) < 32'(spi_fifo_length);
    free_w  = '0;
    if (room)
      free_w = 32'(spi_fifo_length) - 32'(fifo_count);
    free    = (free_w > 32'd31) ? 5'd31 : free_w[4:0];
    set_ovf = (state == COMPLETE) && !room;
    set_frm = (state == ACTIVE) && cs_rise && (bit_cnt != 4'd0);
    clr     = (state == COMPLETE) ? rep : 3'b000;
    ovf_nx  = (overflow & ~clr[2]) | set_ovf;
    inv_nx  = (inv_flag & ~clr[1]) | invalid_command;
    frm_nx  = (framing_error & ~clr[0]) | set_frm;
    status  = {ovf_nx, inv_nx, frm_nx, free};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      bit_cnt           <= 4'd0;
      rx                <= 8'd0;
      tx                <= 7'd0;
      rep               <= 3'b000;
      miso              <= 1'b0;
      command_out       <= 8'd0;
      command_out_valid <= 1'b0;
      overflow          <= 1'b0;
      inv_flag          <= 1'b0;
      framing_error     <= 1'b0;
    end else begin
      command_out_valid <= 1'b0;
      overflow          <= ovf_nx;
      inv_flag          <= inv_nx;
      framing_error     <= frm_nx;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            miso    <= status[7];
            tx      <= status[6:0];
            rep     <= status[7:5];
            bit_cnt <= 4'd0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            bit_cnt <= 4'd0;
            state   <= IDLE;
          end else if (sclk_rise) begin
            rx      <= {rx[6:0], mosi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              state <= COMPLETE;
          end else if (sclk_fall && bit_cnt != 4'd0) begin
            // The fall right after a reload keeps the fresh MSB.
            miso <= tx[6];
            tx   <= {tx[5:0], 1'b0};
          end
        end
        COMPLETE: begin
          if (room) begin
            command_out       <= rx;
            command_out_valid <= 1'b1;
          end
          miso    <= status[7];
          tx      <= status[6:0];
          rep     <= status[7:5];
          bit_cnt <= 4'd0;
          state   <= cs_rise ? IDLE : ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
